// File: rtl/psram_wbuf_bridge.sv
// Posted-write buffer in front of the PSRAM AHB controller. Writes are absorbed
// into a small FIFO and drained one at a time; reads wait for an empty FIFO.
module psram_wbuf_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = 36,
    parameter int DW    = 64
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   S_HSEL,
    input  logic [AW-1:0]          S_HADDR,
    input  logic                   S_HWRITE,
    input  logic [1:0]             S_HTRANS,
    input  logic [2:0]             S_HSIZE,
    input  logic [DW-1:0]          S_HWDATA,
    input  logic                   S_HREADY,
    output logic                   S_HREADYOUT,
    output logic                   S_HRESP,
    output logic [DW-1:0]          S_HRDATA,
    output logic                   M_HSEL,
    output logic [AW-1:0]          M_HADDR,
    output logic                   M_HWRITE,
    output logic [1:0]             M_HTRANS,
    output logic [2:0]             M_HSIZE,
    output logic [2:0]             M_HBURST,
    output logic [DW-1:0]          M_HWDATA,
    input  logic                   M_HREADY,
    input  logic [DW-1:0]          M_HRDATA,
    output logic [$clog2(DEPTH):0] wbuf_level,
    output logic                   wbuf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {D_IDLE, D_REQ, D_BUSY} dstate_t;

    logic [AW-1:0] r_mem_addr [DEPTH];
    logic [2:0]    r_mem_size [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_level;

    logic          r_dp_valid, r_dp_write, r_rd_done;
    logic [AW-1:0] r_dp_addr;
    logic [2:0]    r_dp_size;
    logic [DW-1:0] r_rdata;

    dstate_t       r_dstate, w_dstate_nx;
    logic          r_m_hsel, r_m_hwrite;
    logic [AW-1:0] r_m_haddr;
    logic [2:0]    r_m_hsize;
    logic [DW-1:0] r_m_hwdata;

    logic          w_full, w_empty, w_accept, w_push, w_pop, w_rd_pend;
    logic          w_load_rd, w_load_wr, w_done, w_hreadyout;
    logic [AW-1:0] w_head_addr;
    logic [2:0]    w_head_size;
    logic [DW-1:0] w_head_data;

    assign w_full    = (r_level == FULL_LVL);
    assign w_empty   = (r_level == '0);
    assign w_accept  = S_HSEL & S_HREADY & (S_HTRANS inside {2'b10, 2'b11});
    assign w_push    = r_dp_valid & r_dp_write & ~w_full;
    assign w_pop     = w_done & r_m_hwrite;
    assign w_rd_pend = r_dp_valid & ~r_dp_write & ~r_rd_done;

    // An empty FIFO being pushed this cycle hands its entry straight to the engine.
    assign w_head_addr = w_empty ? r_dp_addr : r_mem_addr[r_rptr];
    assign w_head_size = w_empty ? r_dp_size : r_mem_size[r_rptr];
    assign w_head_data = w_empty ? S_HWDATA  : r_mem_data[r_rptr];

    always_comb begin
        w_hreadyout = 1'b1;
        if (r_dp_valid) begin
            w_hreadyout = r_dp_write ? ~w_full : r_rd_done;
        end
    end

    always_comb begin
        w_dstate_nx = r_dstate;
        w_load_rd   = 1'b0;
        w_load_wr   = 1'b0;
        w_done      = 1'b0;
        case (r_dstate)
            D_IDLE: begin
                if (w_rd_pend && w_empty) begin
                    w_load_rd   = 1'b1;
                    w_dstate_nx = D_REQ;
                end else if (!w_empty || w_push) begin
                    w_load_wr   = 1'b1;
                    w_dstate_nx = D_REQ;
                end
            end
            D_REQ: begin
                if (!M_HREADY) w_dstate_nx = D_BUSY;
            end
            D_BUSY: begin
                if (M_HREADY) begin
                    w_done      = 1'b1;
                    w_dstate_nx = D_IDLE;
                end
            end
            default: w_dstate_nx = D_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= r_dp_addr;
            r_mem_size[r_wptr] <= r_dp_size;
            r_mem_data[r_wptr] <= S_HWDATA;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_size  <= '0;
            r_rd_done  <= 1'b0;
            r_rdata    <= '0;
            r_dstate   <= D_IDLE;
            r_m_hsel   <= 1'b0;
            r_m_hwrite <= 1'b0;
            r_m_haddr  <= '0;
            r_m_hsize  <= '0;
            r_m_hwdata <= '0;
        end else begin
            r_dstate <= w_dstate_nx;
            if (S_HREADY) begin
                r_dp_valid <= w_accept;
                r_dp_write <= S_HWRITE;
                r_dp_addr  <= S_HADDR;
                r_dp_size  <= S_HSIZE;
                r_rd_done  <= 1'b0;
            end
            if (w_done && !r_m_hwrite) begin
                r_rdata   <= M_HRDATA;
                r_rd_done <= 1'b1;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_load_rd) begin
                r_m_hsel   <= 1'b1;
                r_m_hwrite <= 1'b0;
                r_m_haddr  <= r_dp_addr;
                r_m_hsize  <= r_dp_size;
            end else if (w_load_wr) begin
                r_m_hsel   <= 1'b1;
                r_m_hwrite <= 1'b1;
                r_m_haddr  <= w_head_addr;
                r_m_hsize  <= w_head_size;
                r_m_hwdata <= w_head_data;
            end else if (w_done) begin
                r_m_hsel   <= 1'b0;
            end
        end
    end

    assign S_HREADYOUT = w_hreadyout;
    assign S_HRESP     = 1'b0;
    assign S_HRDATA    = r_rdata;
    assign M_HSEL      = r_m_hsel;
    assign M_HADDR     = r_m_haddr;
    assign M_HWRITE    = r_m_hwrite;
    assign M_HTRANS    = r_m_hsel ? 2'b10 : 2'b00;
    assign M_HSIZE     = r_m_hsize;
    assign M_HBURST    = 3'b000;
    assign M_HWDATA    = r_m_hwdata;
    assign wbuf_level  = r_level;
    assign wbuf_empty  = w_empty;

endmodule

// File: tb/tb_psram_wbuf_bridge.sv
// Bench for psram_wbuf_bridge: AHB master driver, PSRAM controller model with
// programmable busy time, and write/read scoreboards.
module tb_psram_wbuf_bridge;

    localparam int AW    = 36;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT, S_HRESP;
    logic [AW-1:0] S_HADDR;
    logic [1:0]    S_HTRANS;
    logic [2:0]    S_HSIZE;
    logic [DW-1:0] S_HWDATA, S_HRDATA;
    logic          M_HSEL, M_HWRITE, M_HREADY;
    logic [AW-1:0] M_HADDR;
    logic [1:0]    M_HTRANS;
    logic [2:0]    M_HSIZE, M_HBURST;
    logic [DW-1:0] M_HWDATA, M_HRDATA;
    logic [2:0]    wbuf_level;
    logic          wbuf_empty;

    psram_wbuf_bridge #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HTRANS(S_HTRANS),
        .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
        .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE), .M_HTRANS(M_HTRANS),
        .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA),
        .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA),
        .wbuf_level(wbuf_level), .wbuf_empty(wbuf_empty)
    );

    always #5 HCLK = ~HCLK;

    // Single slave on the fabric: HREADY is this slave's HREADYOUT.
    assign S_HREADY = S_HREADYOUT;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] smem [logic [AW-1:0]];
    logic [DW-1:0] dmem [logic [AW-1:0]];

    int n_chk = 0;
    int n_fail = 0;
    int busy = 5;
    int n_xfer = 0;
    int last_stall = 0;
    bit in_xfer = 1'b0;

    logic          pend_valid = 1'b0;
    logic          pend_write = 1'b0;
    logic [DW-1:0] pend_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One AHB cycle: drive an address phase plus the data of the previous one,
    // and hold both until the slave is ready. Called at posedge+1, returns at posedge+1.
    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int stalls;
        logic [DW-1:0] exp_rd;
        stalls   = 0;
        S_HSEL   = sel;
        S_HTRANS = trans;
        S_HWRITE = wr;
        S_HADDR  = addr;
        S_HSIZE  = 3'b011;
        S_HWDATA = pend_wdata;
        @(negedge HCLK);
        while (!S_HREADYOUT && stalls < 400) begin
            stalls++;
            @(negedge HCLK);
        end
        if (!S_HREADYOUT) chk("hready_timeout", 64'(S_HREADYOUT), 1);
        last_stall = stalls;
        if (pend_valid && !pend_write) begin
            if (rq.size() > 0) begin
                exp_rd = rq.pop_front();
                chk("s_hrdata", S_HRDATA, exp_rd);
            end
        end
        pend_valid = sel & trans[1];
        pend_write = wr;
        pend_wdata = wdata;
        if (sel && trans[1]) begin
            if (wr) begin
                wq.push_back('{a: addr, d: wdata});
                smem[addr] = wdata;
            end else begin
                rq.push_back(smem.exists(addr) ? smem[addr] : '0);
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 2'b00, 1'b0, '0, '0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!(wbuf_empty && !M_HSEL && !in_xfer) && k < 600) begin
            @(posedge HCLK);
            #2;
            k++;
        end
        if (k >= 600) chk(tag, 64'(wbuf_level), 0);
    endtask

    // PSRAM controller model: drops HREADY for 'busy' cycles per transfer.
    initial begin
        int cnt;
        logic          x_write;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_data;
        wr_t           e;
        cnt = 0;
        M_HREADY = 1'b1;
        M_HRDATA = '0;
        forever begin
            @(posedge HCLK);
            #1;
            if (HRESET) begin
                in_xfer  = 1'b0;
                M_HREADY = 1'b1;
            end else begin
                if (in_xfer) begin
                    if (cnt > 0) begin
                        cnt--;
                        if (cnt == 0) M_HREADY = 1'b1;
                    end else begin
                        in_xfer = 1'b0;
                        if (x_write) dmem[x_addr] = x_data;
                    end
                end
                if (!in_xfer && M_HSEL) begin
                    n_xfer++;
                    in_xfer  = 1'b1;
                    cnt      = busy;
                    M_HREADY = 1'b0;
                    x_write  = M_HWRITE;
                    x_addr   = M_HADDR;
                    x_data   = M_HWDATA;
                    chk("ds_htrans", 64'(M_HTRANS), 2);
                    chk("ds_hburst", 64'(M_HBURST), 0);
                    chk("ds_hsize", 64'(M_HSIZE), 3);
                    if (x_write) begin
                        if (wq.size() == 0) begin
                            chk("ds_wr_extra", 64'(wq.size()), 1);
                        end else begin
                            e = wq.pop_front();
                            chk("ds_waddr", 64'(x_addr), 64'(e.a));
                            chk("ds_wdata", x_data, e.d);
                        end
                    end else begin
                        chk("raw_order", 64'(wq.size()), 0);
                        M_HRDATA = dmem.exists(x_addr) ? dmem[x_addr] : '0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st[7];
        int x0;
        int k;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWRITE = 1'b0;
        S_HADDR = '0; S_HSIZE = '0; S_HWDATA = '0;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", 64'(S_HREADYOUT), 1);
        chk("rst_hresp", 64'(S_HRESP), 0);
        chk("rst_hrdata", S_HRDATA, 0);
        chk("rst_m_hsel", 64'(M_HSEL), 0);
        chk("rst_m_haddr", 64'(M_HADDR), 0);
        chk("rst_m_htrans", 64'(M_HTRANS), 0);
        chk("rst_m_hwdata", M_HWDATA, 0);
        chk("rst_level", 64'(wbuf_level), 0);
        chk("rst_empty", 64'(wbuf_empty), 1);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Posted writes, no wait states, level peaks at 4.
        busy = 5;
        x0 = n_xfer;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b10, 1'b1, 36'h100 + 36'(8 * i), 64'hA0 + 64'(i));
            chk("posted_stall", 64'(last_stall), 0);
        end
        idle_step();
        chk("posted_stall_last", 64'(last_stall), 0);
        chk("posted_peak_level", 64'(wbuf_level), 4);
        wait_idle("posted_drain_timeout");
        chk("posted_level_end", 64'(wbuf_level), 0);
        chk("posted_xfers", 64'(n_xfer - x0), 4);

        // Six writes into a four-entry buffer.
        x0 = n_xfer;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'b10, 1'b1, 36'h300 + 36'(8 * i), 64'hB0 + 64'(i));
            st[i] = last_stall;
        end
        idle_step();
        st[6] = last_stall;
        chk("full_nostall_dp4", 64'(st[4]), 0);
        chk("full_stall_dp5", 64'(st[5] > 0), 1);
        chk("full_stall_dp6", 64'(st[6] > 0), 1);
        chk("full_level_after6", 64'(wbuf_level), 4);
        wait_idle("full_drain_timeout");
        chk("full_xfers", 64'(n_xfer - x0), 6);
        chk("full_level_end", 64'(wbuf_level), 0);

        // Read after write, plus reads of older and never-written addresses.
        busy = 3;
        step(1'b1, 2'b10, 1'b1, 36'h200, 64'hDEAD);
        step(1'b1, 2'b10, 1'b0, 36'h200, '0);
        idle_step();
        chk("raw_read_stalled", 64'(last_stall > 0), 1);
        step(1'b1, 2'b10, 1'b0, 36'h108, '0);
        idle_step();
        step(1'b1, 2'b10, 1'b0, 36'h328, '0);
        step(1'b1, 2'b10, 1'b0, 36'h500, '0);
        idle_step();
        wait_idle("raw_drain_timeout");

        // Controller stuck with HREADY low: entry must stay queued.
        busy = 50;
        step(1'b1, 2'b10, 1'b1, 36'h400, 64'hC0);
        idle_step();
        repeat (30) @(posedge HCLK);
        #1;
        chk("hold_m_hsel", 64'(M_HSEL), 1);
        chk("hold_level", 64'(wbuf_level), 1);
        wait_idle("hold_drain_timeout");
        chk("hold_level_end", 64'(wbuf_level), 0);

        // IDLE and BUSY transfer types are ignored.
        busy = 3;
        x0 = n_xfer;
        step(1'b1, 2'b00, 1'b1, 36'h600, 64'h11);
        chk("idle_hready", 64'(S_HREADYOUT), 1);
        step(1'b1, 2'b01, 1'b1, 36'h608, 64'h22);
        chk("busy_hready", 64'(S_HREADYOUT), 1);
        idle_step();
        repeat (5) @(posedge HCLK);
        #1;
        chk("idle_level", 64'(wbuf_level), 0);
        chk("idle_empty", 64'(wbuf_empty), 1);
        chk("idle_no_xfer", 64'(n_xfer - x0), 0);

        // Reset in the middle of a drain.
        busy = 20;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1, 36'h700 + 36'(8 * i), 64'hD0 + 64'(i));
        idle_step();
        k = 0;
        while (!M_HSEL && k < 20) begin
            @(posedge HCLK);
            #1;
            k++;
        end
        chk("rst_mid_pre_hsel", 64'(M_HSEL), 1);
        @(posedge HCLK);
        #3;
        HRESET = 1'b1;
        #1;
        chk("rst_mid_hsel_async", 64'(M_HSEL), 0);
        chk("rst_mid_level_async", 64'(wbuf_level), 0);
        wq.delete();
        rq.delete();
        pend_valid = 1'b0;
        repeat (2) @(posedge HCLK);
        #2;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        chk("rst_mid_level", 64'(wbuf_level), 0);
        chk("rst_mid_hreadyout", 64'(S_HREADYOUT), 1);
        chk("rst_mid_m_htrans", 64'(M_HTRANS), 0);

        // Bridge usable again after reset.
        busy = 2;
        step(1'b1, 2'b10, 1'b1, 36'h800, 64'hE0);
        step(1'b1, 2'b10, 1'b0, 36'h800, '0);
        idle_step();
        wait_idle("post_rst_drain_timeout");
        chk("post_rst_rq_empty", 64'(rq.size()), 0);
        chk("end_wq_empty", 64'(wq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
